pool_window_gen: RTL and testbench
==================================

POOL_WINDOW_GEN -- requirements
Module: pool_window_gen

Interface
REQ-001 SHALL have parameter INPUT_NUM, default 6, channels per pixel word.
REQ-002 SHALL have parameter IMG_W, default 24, columns per feature map (even, >=2).
REQ-003 SHALL have parameter IMG_H, default 24, rows per feature map (even, >=2).
REQ-004 SHALL have port clk  input  1  sole clock, rising edge.
REQ-005 SHALL have port rst  input  1  reset; one clock, reset is synchronous and active-high.
REQ-006 SHALL have port in_valid  input  1  raster pixel valid.
REQ-007 SHALL have port in_ready  output  1  pixel accepted when in_valid&in_ready.
REQ-008 SHALL have port in_data  input  `WD*INPUT_NUM  signed channels, channel i at [(i+1)*`WD-1:i*`WD].
REQ-009 SHALL have port aa_en  output  1  window burst active.
REQ-010 SHALL have port aa_first_data  output  1  first element of 2x2 window.
REQ-011 SHALL have port aa_last_data  output  1  last element of 2x2 window.
REQ-012 SHALL have port data_o  output  `WD*INPUT_NUM  window element, lagging flags by one cycle.

Function
REQ-013 SHALL accept pixels in raster order; row counter 0..IMG_H-1 and column counter 0..IMG_W-1, both wrap to 0 at frame end.
REQ-014 Even rows: in_ready=1; each accepted pixel written to line buffer at its column; no aa_* activity.
REQ-015 Odd row, even column c: in_ready=1; accepted pixel stored in hold register.
REQ-016 Odd row, odd column c+1: accepting at cycle T SHALL start a 4-cycle burst; in_ready=0 during T+1..T+4, returning to 1 at T+5.
REQ-017 Burst flags: aa_en=1 at T+1..T+4; aa_first_data=1 only at T+1; aa_last_data=1 only at T+4.
REQ-018 Burst data order: data_o = buf[c] at T+2, buf[c+1] at T+3, hold at T+4, pixel(c+1) at T+5; data_o=0 whenever not carrying a burst element.
REQ-019 States: FILL (even row), PAIR0 (odd row, even col), PAIR1 (odd row, odd col), B1, B2, B3, B4; B4 -> PAIR0, or -> FILL when the window just emitted ended its odd row.
REQ-020 Frame wrap: after last window of row IMG_H-1, next accepted pixel is row 0 col 0 of the next frame.
REQ-021 in_valid low in any accepting state: counters and state hold; bubbles between pixels SHALL NOT alter burst content.
REQ-022 in_valid during B1..B4 SHALL be ignored (not accepted).
REQ-023 Line buffer SHALL be written only in FILL and read only in B1..B2; no simultaneous read/write.

Reset
REQ-024 rst=1 at any clock edge: state FILL, counters 0, hold=0, in_ready=1, aa_en=aa_first_data=aa_last_data=0, data_o=0, including mid-burst; line buffer contents are not reset.

Configuration
REQ-025 Macro POOL_FRAME_DONE_EN defined: extra output frame_done (1 bit) pulses one cycle at the cycle data_o carries the last element of the frame's final window; reset value 0.
REQ-026 Macro undefined: no frame_done port, no associated logic; all other behaviour identical.

Structure
REQ-027 `WD and default IMG_W/IMG_H/INPUT_NUM constants SHALL live in global.v; module includes it.
REQ-028 Line buffer SHALL be sub-module pool_line_buf (IMG_W entries, `WD*INPUT_NUM wide, one registered read port, one write port).

Verification
REQ-029 INPUT_NUM=1, WD=8, IMG_W=4, IMG_H=2, pixels 1..8 back-to-back -> windows (1,2,5,6),(3,4,7,8); first/last at burst cycles 1 and 4; data_o one cycle later.
REQ-030 Same stream with in_valid low every other cycle -> identical data_o sequence; in_ready low exactly 4 cycles per window.
REQ-031 rst asserted at B2 of first window -> next cycle all outputs 0, in_ready=1; re-sent frame produces correct windows.
REQ-032 Two frames back-to-back, negative values (-3,-1,-8,-2 in window) -> data order preserved, signed bits unchanged; second frame row counter restarts at 0.
REQ-033 POOL_FRAME_DONE_EN defined, IMG_W=4, IMG_H=4 -> frame_done exactly one pulse per frame, coincident with data_o = pixel 16.
REQ-034 in_valid held high during B1..B4 -> no pixel consumed; column counter advances only on handshakes.

Source files
------------

// File: rtl/pool_window_gen_pkg.sv
// ============================================================================
//  pool_window_gen_pkg
//  Shared types for the 2x2 pooling window generator: FSM state encoding and
//  the output data-path source selector.
//  Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package pool_window_gen_pkg;

  // FILL  : even row, pixels go to the line buffer
  // PAIR0 : odd row, even column, pixel goes to the hold register
  // PAIR1 : odd row, odd column, pixel completes a window
  // B1..B4: window burst, input stalled
  typedef enum logic [2:0] {
    ST_FILL  = 3'd0,
    ST_PAIR0 = 3'd1,
    ST_PAIR1 = 3'd2,
    ST_B1    = 3'd3,
    ST_B2    = 3'd4,
    ST_B3    = 3'd5,
    ST_B4    = 3'd6
  } state_t;

  // Which register feeds data_o in the current cycle
  typedef enum logic [1:0] {
    SEL_NONE = 2'd0,
    SEL_BUF  = 2'd1,
    SEL_HOLD = 2'd2,
    SEL_PIX  = 2'd3
  } sel_t;

  function automatic logic is_burst(input state_t s);
    return (s == ST_B1) || (s == ST_B2) || (s == ST_B3) || (s == ST_B4);
  endfunction

endpackage

`default_nettype wire

// File: rtl/global.v
// ============================================================================
//  global.v
//  Shared word-width and default feature-map geometry for the pooling window
//  generator. Included by every RTL file that needs `WD or the defaults.
//  Revision: 1.0 - initial release
// ============================================================================
`default_nettype none
`ifndef POOL_GLOBAL_V
`define POOL_GLOBAL_V

// Bits per signed channel
`define WD 8
// Default geometry
`define INPUT_NUM_DEF 6
`define IMG_W_DEF 24
`define IMG_H_DEF 24

`endif
`default_nettype wire

// File: rtl/pool_window_gen_line_buf.sv
// ============================================================================
//  pool_line_buf
//  Single line buffer holding the even row of a row pair. One write port and
//  one registered read port; contents are never reset.
//  Ports:
//    clk              clock
//    wr_en/wr_addr/wr_data   write port
//    rd_en/rd_addr    read request, data valid on rd_data the next cycle
//    rd_data          registered read data
//  Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module pool_line_buf #(
  parameter int DEPTH = 24,
  parameter int WIDTH = 48,
  parameter int AW    = 5
) (
  input  logic             clk,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_data
);

  logic [WIDTH-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      r_mem[wr_addr] <= wr_data;
    end
    if (rd_en) begin
      rd_data <= r_mem[rd_addr];
    end
  end

endmodule

`default_nettype wire

// File: rtl/pool_window_gen.sv
// ============================================================================
//  pool_window_gen
//  Converts a raster pixel stream into 2x2 pooling windows. Even rows are
//  buffered; each odd-row pixel pair triggers a 4-cycle burst emitting
//  buf[c], buf[c+1], hold(c), pixel(c+1). Flags lead data_o by one cycle.
//  Optional feature: define POOL_FRAME_DONE_EN to add output frame_done,
//  a one-cycle pulse coincident with the last element of a frame.
//  Ports:
//    clk, rst                 clock, synchronous active-high reset
//    in_valid/in_ready/in_data  pixel input handshake
//    aa_en                    burst active
//    aa_first_data/aa_last_data  first/last burst cycle
//    data_o                   window element (one cycle after the flags)
//    frame_done               (POOL_FRAME_DONE_EN only) end-of-frame pulse
//  Revision: 1.0 - initial release
// ============================================================================
`include "global.v"
`default_nettype none

module pool_window_gen
  import pool_window_gen_pkg::*;
#(
  parameter int INPUT_NUM = `INPUT_NUM_DEF,
  parameter int IMG_W     = `IMG_W_DEF,
  parameter int IMG_H     = `IMG_H_DEF
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [`WD*INPUT_NUM-1:0] in_data,
  output logic                    aa_en,
  output logic                    aa_first_data,
  output logic                    aa_last_data,
`ifdef POOL_FRAME_DONE_EN
  output logic [`WD*INPUT_NUM-1:0] data_o,
  output logic                    frame_done
`else
  output logic [`WD*INPUT_NUM-1:0] data_o
`endif
);

  localparam int DW = `WD * INPUT_NUM;
  localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;

  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);
  localparam logic [CW-1:0] COL_ONE  = CW'(1);
  localparam logic [RW-1:0] ROW_ONE  = RW'(1);

  state_t          r_state;
  sel_t            r_sel;
  logic [CW-1:0]   r_col;
  logic [RW-1:0]   r_row;
  logic [CW-1:0]   r_pair_col;   // even column of the window being emitted
  logic [DW-1:0]   r_hold;
  logic [DW-1:0]   r_pix;

  logic            w_hs;
  logic            w_buf_wr;
  logic            w_buf_rd;
  logic [CW-1:0]   w_rd_addr;
  logic [DW-1:0]   w_rd_data;

  assign w_hs     = in_valid & in_ready;
  assign w_buf_wr = (r_state == ST_FILL) & w_hs;
  assign w_buf_rd = (r_state == ST_B1) | (r_state == ST_B2);
  // B1 fetches the even column, B2 the odd one; data arrives a cycle later
  assign w_rd_addr = (r_state == ST_B2) ? (r_pair_col + COL_ONE) : r_pair_col;

  pool_line_buf #(
    .DEPTH (IMG_W),
    .WIDTH (DW),
    .AW    (CW)
  ) u_line_buf (
    .clk     (clk),
    .wr_en   (w_buf_wr),
    .wr_addr (r_col),
    .wr_data (in_data),
    .rd_en   (w_buf_rd),
    .rd_addr (w_rd_addr),
    .rd_data (w_rd_data)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= ST_FILL;
      r_sel         <= SEL_NONE;
      r_col         <= '0;
      r_row         <= '0;
      r_pair_col    <= '0;
      r_hold        <= '0;
      r_pix         <= '0;
      in_ready      <= 1'b1;
      aa_en         <= 1'b0;
      aa_first_data <= 1'b0;
      aa_last_data  <= 1'b0;
    end else begin
      aa_first_data <= 1'b0;
      aa_last_data  <= 1'b0;
      r_sel         <= SEL_NONE;
      unique case (r_state)
        ST_FILL: begin
          if (w_hs) begin
            if (r_col == COL_LAST) begin
              // even row never the last row, so no frame wrap here
              r_col   <= '0;
              r_row   <= r_row + ROW_ONE;
              r_state <= ST_PAIR0;
            end else begin
              r_col <= r_col + COL_ONE;
            end
          end
        end
        ST_PAIR0: begin
          if (w_hs) begin
            r_hold  <= in_data;
            r_col   <= r_col + COL_ONE;
            r_state <= ST_PAIR1;
          end
        end
        ST_PAIR1: begin
          if (w_hs) begin
            r_pix         <= in_data;
            r_pair_col    <= r_col - COL_ONE;
            in_ready      <= 1'b0;
            aa_en         <= 1'b1;
            aa_first_data <= 1'b1;
            r_state       <= ST_B1;
            if (r_col == COL_LAST) begin
              r_col <= '0;
              r_row <= (r_row == ROW_LAST) ? '0 : (r_row + ROW_ONE);
            end else begin
              r_col <= r_col + COL_ONE;
            end
          end
        end
        ST_B1: begin
          r_sel   <= SEL_BUF;
          r_state <= ST_B2;
        end
        ST_B2: begin
          r_sel   <= SEL_BUF;
          r_state <= ST_B3;
        end
        ST_B3: begin
          r_sel        <= SEL_HOLD;
          aa_last_data <= 1'b1;
          r_state      <= ST_B4;
        end
        ST_B4: begin
          r_sel    <= SEL_PIX;
          in_ready <= 1'b1;
          aa_en    <= 1'b0;
          // column already wrapped to 0 means the odd row just finished
          r_state  <= (r_col == '0) ? ST_FILL : ST_PAIR0;
        end
        default: begin
          r_state  <= ST_FILL;
          in_ready <= 1'b1;
          aa_en    <= 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    data_o = '0;
    case (r_sel)
      SEL_BUF:  data_o = w_rd_data;
      SEL_HOLD: data_o = r_hold;
      SEL_PIX:  data_o = r_pix;
      default:  data_o = '0;
    endcase
  end

`ifdef POOL_FRAME_DONE_EN
  logic r_last_win;   // window in flight is the final one of the frame

  always_ff @(posedge clk) begin
    if (rst) begin
      r_last_win <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= (r_state == ST_B4) & r_last_win;
      if ((r_state == ST_PAIR1) && w_hs) begin
        r_last_win <= (r_row == ROW_LAST) && (r_col == COL_LAST);
      end
    end
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_pool_window_gen.sv
// ============================================================================
//  tb_pool_window_gen
//  Self-checking bench for pool_window_gen: a cycle table for the first row
//  pair, a mid-burst reset sequence, and randomized frames checked against a
//  window-order model built from the frame contents.
//  Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pool_window_gen;

  localparam int WD        = 8;
  localparam int INPUT_NUM = 2;
  localparam int W         = 4;
  localparam int H         = 4;
  localparam int DW        = WD * INPUT_NUM;
  localparam int NTBL      = 18;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [DW-1:0] in_data = '0;
  logic          aa_en;
  logic          aa_first_data;
  logic          aa_last_data;
  logic [DW-1:0] data_o;
`ifdef POOL_FRAME_DONE_EN
  logic          frame_done;
`endif

  pool_window_gen #(
    .INPUT_NUM (INPUT_NUM),
    .IMG_W     (W),
    .IMG_H     (H)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_data       (in_data),
    .aa_en         (aa_en),
    .aa_first_data (aa_first_data),
    .aa_last_data  (aa_last_data),
`ifdef POOL_FRAME_DONE_EN
    .data_o        (data_o),
    .frame_done    (frame_done)
`else
    .data_o        (data_o)
`endif
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // channel 0 = p, channel 1 = -p (exercises signed content)
  function automatic logic [DW-1:0] px(input int p);
    logic [WD-1:0] a;
    a = WD'(p);
    return {(-a), a};
  endfunction

  // -------------------------------------------------------------- table
  typedef struct {
    logic          v;
    logic [DW-1:0] d;
    logic          rdy;
    logic          en;
    logic          fst;
    logic          lst;
    logic [DW-1:0] q;
  } vec_t;

  vec_t tbl[NTBL];

  task automatic fill_tbl();
    for (int i = 0; i < NTBL; i++)
      tbl[i] = '{v: 1'b0, d: '0, rdy: 1'b1, en: 1'b0, fst: 1'b0, lst: 1'b0, q: '0};
    for (int i = 0; i < 6; i++) begin
      tbl[i].v = 1'b1; tbl[i].d = px(i + 1);
    end
    // burst 1: pixel 7 offered but must not be taken
    for (int i = 6; i < 10; i++) begin
      tbl[i].v = 1'b1; tbl[i].d = px(7); tbl[i].rdy = 1'b0; tbl[i].en = 1'b1;
    end
    tbl[6].fst = 1'b1; tbl[9].lst = 1'b1;
    tbl[10].v = 1'b1; tbl[10].d = px(7);
    tbl[11].v = 1'b1; tbl[11].d = px(8);
    for (int i = 12; i < 16; i++) begin
      tbl[i].v = 1'b1; tbl[i].d = px(9); tbl[i].rdy = 1'b0; tbl[i].en = 1'b1;
    end
    tbl[12].fst = 1'b1; tbl[15].lst = 1'b1;
    tbl[7].q  = px(1); tbl[8].q  = px(2); tbl[9].q  = px(5); tbl[10].q = px(6);
    tbl[13].q = px(3); tbl[14].q = px(4); tbl[15].q = px(7); tbl[16].q = px(8);
  endtask

  // -------------------------------------------------------------- model / monitor
  logic [DW-1:0] exp_q[$];
  int            pos;
  logic          prev_en;
  int            elem_cnt;

  task automatic mon_reset();
    pos = 0; prev_en = 1'b0; elem_cnt = 0; exp_q.delete();
  endtask

  task automatic mon_check();
    logic fd_exp;
    chk("ready_vs_burst", 32'(in_ready), 32'(!aa_en));
    if (aa_en) pos = prev_en ? pos + 1 : 1;
    chk("first_flag", 32'(aa_first_data), 32'(aa_en && pos == 1));
    chk("last_flag", 32'(aa_last_data), 32'(aa_en && pos == 4));
    if (!aa_en && prev_en) chk("burst_len", 32'(pos), 32'd4);
    fd_exp = 1'b0;
    if (prev_en) begin
      if (exp_q.size() == 0) begin
        chk("extra_element", 32'(data_o), 32'hdead_beef);
      end else begin
        chk("window_data", 32'(data_o), 32'(exp_q.pop_front()));
      end
      fd_exp = ((elem_cnt % (W * H)) == (W * H - 1));
      elem_cnt++;
    end else begin
      chk("idle_data", 32'(data_o), 32'd0);
    end
`ifdef POOL_FRAME_DONE_EN
    chk("frame_done", 32'(frame_done), 32'(fd_exp));
`else
    if (fd_exp) elem_cnt = elem_cnt + 0;
`endif
    prev_en = aa_en;
  endtask

  // Streams nframes random frames with in_valid dropped bubble_pct% of cycles.
  task automatic run_frames(input int nframes, input int bubble_pct);
    logic [DW-1:0] fr[H][W];
    logic [DW-1:0] pix_q[$];
    logic          rdy_s;
    int            guard;
    mon_reset();
    for (int f = 0; f < nframes; f++) begin
      for (int r = 0; r < H; r++)
        for (int c = 0; c < W; c++) begin
          fr[r][c] = DW'($urandom);
          pix_q.push_back(fr[r][c]);
        end
      for (int r = 0; r < H; r += 2)
        for (int c = 0; c < W; c += 2) begin
          exp_q.push_back(fr[r][c]);
          exp_q.push_back(fr[r][c+1]);
          exp_q.push_back(fr[r+1][c]);
          exp_q.push_back(fr[r+1][c+1]);
        end
    end
    guard = 0;
    do begin
      mon_check();
      if (pix_q.size() > 0 && $urandom_range(99) >= bubble_pct) begin
        in_valid = 1'b1; in_data = pix_q[0];
      end else begin
        in_valid = 1'b0; in_data = DW'($urandom);
      end
      rdy_s = in_ready;
      @(negedge clk);
      guard++;
      if (in_valid && rdy_s) void'(pix_q.pop_front());
    end while ((pix_q.size() > 0 || exp_q.size() > 0 || prev_en || aa_en) && guard < 2000);
    in_valid = 1'b0;
    if (guard >= 2000) chk("stream_timeout", 32'(exp_q.size()), 32'd0);
    mon_check();
    @(negedge clk);
    mon_check();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; in_valid = 1'b0; in_data = '0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  // -------------------------------------------------------------- main
  initial begin
    fill_tbl();
    do_reset();

    // Table: first row pair, back-to-back, pixels offered during bursts
    for (int i = 0; i < NTBL; i++) begin
      chk($sformatf("tbl%0d_ready", i), 32'(in_ready), 32'(tbl[i].rdy));
      chk($sformatf("tbl%0d_en", i), 32'(aa_en), 32'(tbl[i].en));
      chk($sformatf("tbl%0d_first", i), 32'(aa_first_data), 32'(tbl[i].fst));
      chk($sformatf("tbl%0d_last", i), 32'(aa_last_data), 32'(tbl[i].lst));
      chk($sformatf("tbl%0d_data", i), 32'(data_o), 32'(tbl[i].q));
`ifdef POOL_FRAME_DONE_EN
      chk($sformatf("tbl%0d_fdone", i), 32'(frame_done), 32'd0);
`endif
      in_valid = tbl[i].v;
      in_data  = tbl[i].d;
      @(negedge clk);
    end

    // Reset in the middle of a burst (at B2)
    do_reset();
    for (int i = 0; i < 6; i++) begin
      chk("rst_seq_ready", 32'(in_ready), 32'd1);
      in_valid = 1'b1; in_data = px(20 + i);
      @(negedge clk);
    end
    chk("rst_seq_b1_first", 32'(aa_first_data), 32'd1);
    @(negedge clk);
    chk("rst_seq_b2_en", 32'(aa_en), 32'd1);
    chk("rst_seq_b2_ready", 32'(in_ready), 32'd0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; in_valid = 1'b0;
    chk("post_rst_en", 32'(aa_en), 32'd0);
    chk("post_rst_first", 32'(aa_first_data), 32'd0);
    chk("post_rst_last", 32'(aa_last_data), 32'd0);
    chk("post_rst_data", 32'(data_o), 32'd0);
    chk("post_rst_ready", 32'(in_ready), 32'd1);
`ifdef POOL_FRAME_DONE_EN
    chk("post_rst_fdone", 32'(frame_done), 32'd0);
`endif

    // Re-sent frame, then bubbled multi-frame streams
    run_frames(1, 0);
    run_frames(2, 50);
    run_frames(2, 25);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached, compared %0d mismatched %0d", n_cmp, n_bad);
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
